// File: rtl/imem_boot_loader_pkg.sv
// Shared types and constants for the instruction-memory boot loader.
package imem_boot_loader_pkg;

  // Stream framing: big-endian length header, then big-endian words.
  localparam int LEN_BYTES      = 2;
  localparam int BYTES_PER_WORD = 4;
  localparam int LEN_W          = 8 * LEN_BYTES;

  // Instruction word as seen by the processor's instruction memory.
  typedef logic [31:0] instr_word_t;

  // Loader FSM state encoding.
  typedef logic [2:0] state_t;
  localparam state_t ST_IDLE   = 3'd0;
  localparam state_t ST_LEN_HI = 3'd1;
  localparam state_t ST_LEN_LO = 3'd2;
  localparam state_t ST_DATA   = 3'd3;
  localparam state_t ST_DONE   = 3'd4;
  localparam state_t ST_ERR    = 3'd5;

  // A program length is legal when it is non-zero and fits the memory budget.
  function automatic logic len_legal(input logic [LEN_W-1:0] len,
                                     input int unsigned max_words);
    return (len != '0) && (32'(len) <= max_words);
  endfunction

endpackage

// File: rtl/imem_boot_loader_if.sv
// Byte-stream input and instruction-memory write port of the boot loader.
//
// Handshake: a byte moves on a rising edge where in_valid and in_ready are
// both 1. The source holds in_data stable while in_valid is high and not yet
// accepted; in_ready depends only on loader state, never on in_valid.
// imem_we is a single-cycle strobe; imem_addr/imem_wdata are valid with it
// and hold their previous values while it is low.
interface imem_boot_loader_if #(
  parameter int ADDR_W = 8
);
  import imem_boot_loader_pkg::*;

  logic              in_valid;
  logic [7:0]        in_data;
  logic              in_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  instr_word_t       imem_wdata;

  // Byte source / memory observer side.
  modport master (
    output in_valid, in_data,
    input  in_ready, imem_we, imem_addr, imem_wdata
  );

  // Loader side.
  modport slave (
    input  in_valid, in_data,
    output in_ready, imem_we, imem_addr, imem_wdata
  );

endinterface

// File: rtl/imem_boot_loader_byte_word_packer.sv
// Packs accepted bytes into big-endian 32-bit words; the first byte of a
// word lands in [31:24]. word_valid pulses combinationally with the 4th byte
// and word carries the complete word in that same cycle.
module imem_boot_loader_byte_word_packer
  import imem_boot_loader_pkg::*;
(
  input  logic        ref_clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        byte_en,
  input  logic [7:0]  byte_in,
  output logic        word_valid,
  output instr_word_t word
);

  logic [1:0]  byte_cnt;
  // Only the first three bytes need storing; the 4th is taken straight
  // from byte_in when the word completes.
  logic [23:0] byte_sr;

  // Byte counter and shift register; clear restarts word alignment.
  always_ff @(posedge ref_clk) begin
    if (!reset) begin
      byte_cnt <= '0;
      byte_sr  <= '0;
    end else if (clear) begin
      byte_cnt <= '0;
      byte_sr  <= '0;
    end else if (byte_en) begin
      byte_cnt <= byte_cnt + 2'd1;
      byte_sr  <= {byte_sr[15:0], byte_in};
    end
  end

  assign word_valid = byte_en && !clear && (byte_cnt == 2'(BYTES_PER_WORD - 1));
  assign word       = {byte_sr, byte_in};

endmodule

// File: rtl/imem_boot_loader.sv
// Boot loader: reads a length-prefixed byte stream, writes the packed words
// into instruction memory from address 0, then releases the processor.
module imem_boot_loader
  import imem_boot_loader_pkg::*;
#(
  parameter int ADDR_W    = 8,
  parameter int MAX_WORDS = 256
) (
  input  logic              ref_clk,
  input  logic              reset,
  input  logic              start,
  imem_boot_loader_if.slave bus,
  output logic              cpu_run,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADDR_W:0]   words_loaded,
  output state_t            state_dbg
);

  state_t            state;
  logic [LEN_W-1:0]  len_q;
  logic              last_pending;   // word in flight is the final one
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  instr_word_t       wdata_q;

  logic              in_ready;
  logic              hs;
  logic              pk_clear;
  logic              pk_byte_en;
  logic              pk_word_valid;
  instr_word_t       pk_word;
  logic [LEN_W-1:0]  len_full;

  // Stop accepting once the last word is being written so trailing bytes
  // stay in the source.
  always_comb begin
    in_ready = 1'b0;
    case (state)
      ST_LEN_HI, ST_LEN_LO: in_ready = 1'b1;
      ST_DATA:              in_ready = !last_pending;
      default:              in_ready = 1'b0;
    endcase
  end

  assign hs         = bus.in_valid && in_ready;
  assign pk_clear   = (state != ST_DATA);
  assign pk_byte_en = hs && (state == ST_DATA);
  assign len_full   = {len_q[LEN_W-1:8], bus.in_data};

  imem_boot_loader_byte_word_packer u_packer (
    .ref_clk    (ref_clk),
    .reset      (reset),
    .clear      (pk_clear),
    .byte_en    (pk_byte_en),
    .byte_in    (bus.in_data),
    .word_valid (pk_word_valid),
    .word       (pk_word)
  );

  // Loader FSM: header capture, word counting and completion/error exits.
  always_ff @(posedge ref_clk) begin
    if (!reset) begin
      state        <= ST_IDLE;
      len_q        <= '0;
      words_loaded <= '0;
      last_pending <= 1'b0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE, ST_ERR: begin
          if (start) begin
            state        <= ST_LEN_HI;
            words_loaded <= '0;
            last_pending <= 1'b0;
          end
        end
        ST_LEN_HI: begin
          if (hs) begin
            len_q[LEN_W-1:8] <= bus.in_data;
            state            <= ST_LEN_LO;
          end
        end
        ST_LEN_LO: begin
          if (hs) begin
            len_q <= len_full;
            state <= len_legal(len_full, MAX_WORDS) ? ST_DATA : ST_ERR;
          end
        end
        ST_DATA: begin
          if (pk_word_valid)
            last_pending <= (LEN_W'(words_loaded) + LEN_W'(1) == len_q);
          // Count the word in the cycle its write strobe is high.
          if (we_q) begin
            words_loaded <= words_loaded + 1'b1;
            if (last_pending)
              state <= ST_DONE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Write port: capture word and address on the 4th byte, strobe next cycle.
  always_ff @(posedge ref_clk) begin
    if (!reset) begin
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      we_q <= pk_word_valid;
      if (pk_word_valid) begin
        addr_q  <= words_loaded[ADDR_W-1:0];
        wdata_q <= pk_word;
      end
    end
  end

  assign bus.in_ready   = in_ready;
  assign bus.imem_we    = we_q;
  assign bus.imem_addr  = addr_q;
  assign bus.imem_wdata = wdata_q;

  assign busy      = (state == ST_LEN_HI) || (state == ST_LEN_LO) || (state == ST_DATA);
  assign done      = (state == ST_DONE);
  assign cpu_run   = (state == ST_DONE);
  assign err       = (state == ST_ERR);
  assign state_dbg = state;

endmodule

// File: tb/tb_imem_boot_loader.sv
// Directed bench for imem_boot_loader: normal load, bad headers, stalled
// stream, mid-load reset and restart from DONE.
module tb_imem_boot_loader;
  import imem_boot_loader_pkg::*;

  localparam int ADDR_W = 8;

  // Clock / reset
  logic ref_clk = 1'b0;
  logic reset   = 1'b0;
  logic start   = 1'b0;
  always #5 ref_clk = ~ref_clk;

  logic            cpu_run, busy, done, err;
  logic [ADDR_W:0] words_loaded;
  state_t          state_dbg;

  imem_boot_loader_if #(.ADDR_W(ADDR_W)) bus ();

  imem_boot_loader #(.ADDR_W(ADDR_W), .MAX_WORDS(256)) dut (
    .ref_clk      (ref_clk),
    .reset        (reset),
    .start        (start),
    .bus          (bus),
    .cpu_run      (cpu_run),
    .busy         (busy),
    .done         (done),
    .err          (err),
    .words_loaded (words_loaded),
    .state_dbg    (state_dbg)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Scoreboard: expected {addr, data} per imem_we pulse
  logic [ADDR_W+31:0] exp_q[$];
  logic [ADDR_W+31:0] mon_exp;

  always @(negedge ref_clk) begin
    if (bus.imem_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        check_eq("unexpected_we", 64'(bus.imem_we), 64'd0);
      end else begin
        mon_exp = exp_q.pop_front();
        check_eq("we_addr", 64'(bus.imem_addr), 64'(mon_exp[ADDR_W+31:32]));
        check_eq("we_data", 64'(bus.imem_wdata), 64'(mon_exp[31:0]));
      end
    end
  end

  // Driver tasks
  logic [7:0] stim[16];
  int         stim_n = 0;

  task automatic tick();
    @(posedge ref_clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic put(input logic [7:0] b);
    stim[stim_n] = b;
    stim_n++;
  endtask

  task automatic put_len(input logic [15:0] len);
    put(len[15:8]);
    put(len[7:0]);
  endtask

  task automatic put4(input logic [31:0] w);
    put(w[31:24]);
    put(w[23:16]);
    put(w[15:8]);
    put(w[7:0]);
  endtask

  // Returns 1ns after the edge that accepted the last byte.
  task automatic send_stream(input int stall_pct);
    int   idx = 0;
    int   cyc = 0;
    logic hs;
    while (idx < stim_n && cyc < 400) begin
      bus.in_valid = ($urandom_range(99) >= stall_pct);
      bus.in_data  = stim[idx];
      @(negedge ref_clk);
      hs = bus.in_valid && bus.in_ready;
      tick();
      if (hs) idx++;
      cyc++;
    end
    bus.in_valid = 1'b0;
    check_eq("stream_sent", 64'(idx), 64'(stim_n));
    stim_n = 0;
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_in_ready"}, 64'(bus.in_ready), 64'd0);
    check_eq({tag, "_we"}, 64'(bus.imem_we), 64'd0);
    check_eq({tag, "_addr"}, 64'(bus.imem_addr), 64'd0);
    check_eq({tag, "_wdata"}, 64'(bus.imem_wdata), 64'd0);
    check_eq({tag, "_cpu_run"}, 64'(cpu_run), 64'd0);
    check_eq({tag, "_busy"}, 64'(busy), 64'd0);
    check_eq({tag, "_done"}, 64'(done), 64'd0);
    check_eq({tag, "_err"}, 64'(err), 64'd0);
    check_eq({tag, "_words"}, 64'(words_loaded), 64'd0);
    check_eq({tag, "_state"}, 64'(state_dbg), 64'(ST_IDLE));
  endtask

  task automatic load_two_words(input int stall_pct, input string tag);
    put_len(16'd2);
    put4(32'hDEADBEEF);
    put4(32'h12345678);
    exp_q.push_back({8'd0, 32'hDEADBEEF});
    exp_q.push_back({8'd1, 32'h12345678});
    send_stream(stall_pct);
    // Final write cycle: strobe high, no more bytes, processor still held.
    check_eq({tag, "_last_we"}, 64'(bus.imem_we), 64'd1);
    check_eq({tag, "_last_ready"}, 64'(bus.in_ready), 64'd0);
    check_eq({tag, "_run_early"}, 64'(cpu_run), 64'd0);
    tick();
    check_eq({tag, "_done"}, 64'(done), 64'd1);
    check_eq({tag, "_cpu_run"}, 64'(cpu_run), 64'd1);
    check_eq({tag, "_busy"}, 64'(busy), 64'd0);
    check_eq({tag, "_words"}, 64'(words_loaded), 64'd2);
    check_eq({tag, "_pending"}, 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;

    // Reset state
    reset = 1'b0;
    tick();
    tick();
    check_all_zero("reset");
    reset = 1'b1;
    tick();

    // Normal load, then trailing byte must not be consumed
    pulse_start();
    check_eq("start_busy", 64'(busy), 64'd1);
    check_eq("start_ready", 64'(bus.in_ready), 64'd1);
    load_two_words(0, "normal");
    bus.in_valid = 1'b1;
    bus.in_data  = 8'h99;
    tick();
    check_eq("trail_ready", 64'(bus.in_ready), 64'd0);
    check_eq("trail_done", 64'(done), 64'd1);
    bus.in_valid = 1'b0;

    // Restart from DONE
    pulse_start();
    check_eq("restart_run", 64'(cpu_run), 64'd0);
    check_eq("restart_done", 64'(done), 64'd0);
    check_eq("restart_words", 64'(words_loaded), 64'd0);
    put_len(16'd1);
    put4(32'hAABBCCDD);
    exp_q.push_back({8'd0, 32'hAABBCCDD});
    send_stream(0);
    tick();
    check_eq("restart_run2", 64'(cpu_run), 64'd1);
    check_eq("restart_words2", 64'(words_loaded), 64'd1);
    check_eq("restart_hold_data", 64'(bus.imem_wdata), 64'hAABBCCDD);
    check_eq("restart_hold_addr", 64'(bus.imem_addr), 64'd0);

    // Zero-length header
    pulse_start();
    put_len(16'd0);
    send_stream(0);
    tick();
    check_eq("len0_err", 64'(err), 64'd1);
    check_eq("len0_busy", 64'(busy), 64'd0);
    check_eq("len0_run", 64'(cpu_run), 64'd0);
    check_eq("len0_done", 64'(done), 64'd0);
    check_eq("len0_state", 64'(state_dbg), 64'(ST_ERR));

    // Over-long header (257 words)
    pulse_start();
    check_eq("len257_err_clr", 64'(err), 64'd0);
    put_len(16'h0101);
    send_stream(0);
    tick();
    check_eq("len257_err", 64'(err), 64'd1);
    check_eq("len257_words", 64'(words_loaded), 64'd0);
    check_eq("len257_run", 64'(cpu_run), 64'd0);

    // Bytes before start are ignored
    bus.in_valid = 1'b1;
    bus.in_data  = 8'h55;
    tick();
    tick();
    check_eq("prestart_ready", 64'(bus.in_ready), 64'd0);
    bus.in_valid = 1'b0;

    // Stalled stream gives the same result as the normal load
    pulse_start();
    load_two_words(50, "stall");

    // Reset mid-load: header 00 03 plus 5 data bytes
    pulse_start();
    put_len(16'd3);
    put4(32'h11223344);
    put(8'h55);
    exp_q.push_back({8'd0, 32'h11223344});
    send_stream(0);
    check_eq("mid_words", 64'(words_loaded), 64'd1);
    reset = 1'b0;
    tick();
    check_all_zero("midrst");
    reset = 1'b1;
    pulse_start();
    put_len(16'd1);
    put4(32'h0000000C);
    exp_q.push_back({8'd0, 32'h0000000C});
    send_stream(0);
    tick();
    check_eq("fresh_done", 64'(done), 64'd1);
    check_eq("fresh_words", 64'(words_loaded), 64'd1);
    check_eq("fresh_data", 64'(bus.imem_wdata), 64'h0000000C);
    check_eq("fresh_pending", 64'(exp_q.size()), 64'd0);

    tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
